// File: rtl/otter_bus_pkg.sv
// Shared OTTER data-bus types and constants.
// Used by the MEM-side request splitter and its helpers.
package otter_bus_pkg;

    localparam logic [31:0] MMIO_BASE_DEF = 32'h1100_0000;

    typedef enum logic {
        TGT_MEM  = 1'b0,
        TGT_MMIO = 1'b1
    } tgt_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/outstanding_ctr.sv
// Saturating up/down count of reads awaiting a response.
// Simultaneous inc and dec leave the count unchanged.
module outstanding_ctr #(
    parameter  int MAX_OUT = 4,
    localparam int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic empty
);

    logic [CNT_W-1:0] cnt;

    assign full  = (cnt == CNT_W'(MAX_OUT));
    assign empty = (cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && !dec && !full) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc && !empty) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    // The splitter's blocking rule must keep these from ever firing.
    a_no_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(inc && !dec && full));
    a_no_udf: assert property (@(posedge clk) disable iff (!rst_n)
        !(dec && !inc && empty));

endmodule

// File: rtl/bus_split_1to2.sv
// One-to-two request splitter: data memory below MMIO_BASE, MMIO above.
// Reads to one target must drain before switching, keeping returns in order.
module bus_split_1to2
    import otter_bus_pkg::*;
#(
    parameter  logic [31:0] MMIO_BASE = MMIO_BASE_DEF,
    parameter  int          MAX_OUT   = 4,
    localparam int          CNT_W     = $clog2(MAX_OUT + 1)
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [3:0]  req_be,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        err,
    output logic        t0_valid,
    input  logic        t0_ready,
    output logic [31:0] t0_addr,
    output logic [31:0] t0_wdata,
    output logic        t0_we,
    output logic [3:0]  t0_be,
    input  logic        t0_rvalid,
    input  logic [31:0] t0_rdata,
    output logic        t1_valid,
    input  logic        t1_ready,
    output logic [31:0] t1_addr,
    output logic [31:0] t1_wdata,
    output logic        t1_we,
    output logic [3:0]  t1_be,
    input  logic        t1_rvalid,
    input  logic [31:0] t1_rdata
);

    bus_req_t    req;
    tgt_t        sel;
    tgt_t        cur_tgt;
    logic        full;
    logic        empty;
    logic        rv_cur;
    logic        rv_other;
    logic [31:0] rd_cur;
    logic        dec;
    logic        block;
    logic        tgt_ready;
    logic        fwd;
    logic        accept;
    logic        unexp;

    assign req = '{addr: req_addr, we: req_we, be: req_be, wdata: req_wdata};

    assign t0_addr  = req.addr;
    assign t1_addr  = req.addr;
    assign t0_wdata = req.wdata;
    assign t1_wdata = req.wdata;
    assign t0_we    = req.we;
    assign t1_we    = req.we;
    assign t0_be    = req.be;
    assign t1_be    = req.be;

    assign sel = (req_addr >= MMIO_BASE) ? TGT_MMIO : TGT_MEM;

    assign rv_cur   = (cur_tgt == TGT_MMIO) ? t1_rvalid : t0_rvalid;
    assign rv_other = (cur_tgt == TGT_MMIO) ? t0_rvalid : t1_rvalid;
    assign rd_cur   = (cur_tgt == TGT_MMIO) ? t1_rdata  : t0_rdata;

    assign dec   = !empty && rv_cur;
    assign block = (!empty && (sel != cur_tgt))
                 || (!req.we && full && !dec);

    assign tgt_ready = (sel == TGT_MMIO) ? t1_ready : t0_ready;
    assign fwd       = RST_N && !block;
    assign req_ready = fwd && tgt_ready;
    assign t0_valid  = req_valid && fwd && (sel == TGT_MEM);
    assign t1_valid  = req_valid && fwd && (sel == TGT_MMIO);
    assign accept    = req_valid && req_ready;

    assign unexp = rv_other || (empty && (t0_rvalid || t1_rvalid));

    outstanding_ctr #(
        .MAX_OUT (MAX_OUT)
    ) u_ctr (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (accept && !req.we),
        .dec   (dec),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            err        <= 1'b0;
            cur_tgt    <= TGT_MEM;
        end else begin
            resp_valid <= dec;
            if (dec) resp_rdata <= rd_cur;
            if (unexp) err <= 1'b1;
            if (accept) cur_tgt <= sel;
        end
    end

endmodule
